board_input_conditioner: RTL and testbench
==========================================

// Module: board_input_conditioner
// PURPOSE
//   Board-side input front end for the processor: conditions raw FPGA pins
//   (sw[15:0], btnL, btnR) before they reach the core. Synchronises every input
//   into clk0, debounces it, and emits a clean level per input plus a one-cycle
//   rising-edge pulse per button. Sits between the board pins and the
//   processor's sw/rst0/en0 inputs. Used for single-step enable and reset request.
// PARAMETERS
//   SW_WIDTH         16         number of slide switches
//   SYNC_STAGES      2          synchroniser flops per input (>=2)
//   DEBOUNCE_CYCLES  1000000    stable cycles required (10 ms @ 100 MHz); >=2
//   CNT_WIDTH        20         debounce counter width; 2**CNT_WIDTH >= DEBOUNCE_CYCLES
// PORTS
//   clk0        in   1         system clock (100 MHz)
//   rst0        in   1         synchronous, active-low reset
//   sw_raw      in   SW_WIDTH  raw switch pins
//   btnL_raw    in   1         raw left button pin
//   btnR_raw    in   1         raw right button pin
//   sw_clean    out  SW_WIDTH  debounced switch vector
//   btnL_level  out  1         debounced left button level
//   btnR_level  out  1         debounced right button level
//   btnL_pulse  out  1         1-cycle pulse on debounced 0->1 of btnL
//   btnR_pulse  out  1         1-cycle pulse on debounced 0->1 of btnR
// BEHAVIOUR
//   Reset (rst0==0 at a clk0 edge): all synchroniser flops, counters, levels and
//     pulses <= 0. Reset dominates every other event. Reset mid-debounce discards
//     the in-progress count.
//   Sync: each input passes through SYNC_STAGES flops. syn_x = last stage.
//   Button debounce (independent for L and R; each has its own counter):
//     - syn == level: cnt <= 0.
//     - syn != level, cnt <  DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//     - syn != level, cnt == DEBOUNCE_CYCLES-1: level <= syn, cnt <= 0.
//     - Any return to syn==level before terminal count clears cnt. No change occurs.
//   Switch debounce (one shared counter for the whole vector):
//     - Also register syn_sw_d (previous syn_sw).
//     - syn_sw != syn_sw_d (any bit moved): cnt <= 0.
//     - Else if syn_sw != sw_clean: count as above. At terminal count,
//       sw_clean <= syn_sw (whole vector at once).
//     - Else cnt <= 0.
//   Pulse: btnX_pulse is registered. It is high for exactly the cycle following
//     the edge where btnX_level goes 0->1, i.e. it asserts in the same cycle
//     btnX_level first reads 1. No pulse is generated on 1->0.
//   Latency: a clean raw step held steady updates the level/sw_clean
//     SYNC_STAGES+DEBOUNCE_CYCLES edges after the raw change.
//     The switch path adds 1 edge for the syn_sw_d compare.
//   Simultaneous L and R: fully independent. Both may pulse in the same cycle.
//   Counter never wraps: it is cleared at the terminal count.
//   No combinational path from any input to any output.
// TESTING (bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//   1 Hold rst0=0 3 cycles, all raw inputs 1 -> all outputs 0. Release with
//     btnR_raw=1 held -> btnR_pulse=1 for exactly 1 cycle, 6 edges after release.
//     btnR_level then stays 1.
//   2 btnR_raw bounces 1,0,1,0 (1 cycle each), then holds 1 -> exactly one
//     btnR_pulse, 6 edges after the final hold starts. No earlier level change.
//   3 btnL_raw high for 3 cycles then low -> btnL_level stays 0. No btnL_pulse.
//   4 sw_raw 0x0000->0xA5A5, then 0xA5A4 after 3 cycles, held -> sw_clean
//     never shows 0xA5A5. It becomes 0xA5A4 7 edges after the second change.
//   5 btnL_raw, btnR_raw rise together -> both pulses in the same cycle. Both
//     released -> levels fall 6 edges later, no pulses.
//   6 btnL_raw held 1, rst0=0 for 1 cycle at debounce count 2 -> count restarts.
//     btnL_pulse occurs 6 edges after rst0 returns to 1.

Source files
------------

// File: rtl/board_input_conditioner.sv
// Board pin front end: synchronises raw switches and buttons into clk0, debounces them,
// and produces clean levels plus a one-cycle rising-edge pulse per button.
module board_input_conditioner #(
  parameter int SW_WIDTH        = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                clk0,
  input  logic                rst0,
  input  logic [SW_WIDTH-1:0] sw_raw,
  input  logic                btnL_raw,
  input  logic                btnR_raw,
  output logic [SW_WIDTH-1:0] sw_clean,
  output logic                btnL_level,
  output logic                btnR_level,
  output logic                btnL_pulse,
  output logic                btnR_pulse
);

  localparam int IN_W = SW_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] TERM_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [IN_W-1:0]     raw_in;
  logic [IN_W-1:0]     sync_q [SYNC_STAGES];
  logic [IN_W-1:0]     syn_all;
  logic [SW_WIDTH-1:0] syn_sw;
  logic [1:0]          syn_btn;
  logic [1:0]          btn_level;
  logic [1:0]          btn_pulse;

  // Buttons ride in the top two bits: bit SW_WIDTH is L, bit SW_WIDTH+1 is R.
  assign raw_in  = {btnR_raw, btnL_raw, sw_raw};
  assign syn_all = sync_q[SYNC_STAGES-1];
  assign syn_sw  = syn_all[SW_WIDTH-1:0];
  assign syn_btn = syn_all[IN_W-1 -: 2];

  always_ff @(posedge clk0) begin
    if (!rst0) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic                 level_q, level_d;
      logic                 pulse_q, pulse_d;

      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (syn_btn[gi] != level_q) begin
          if (cnt_q == TERM_CNT) level_d = syn_btn[gi];
          else                   cnt_d   = cnt_q + 1'b1;
        end
        pulse_d = level_d & ~level_q;
      end

      always_ff @(posedge clk0) begin
        if (!rst0) begin
          cnt_q   <= '0;
          level_q <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          level_q <= level_d;
          pulse_q <= pulse_d;
        end
      end

      assign btn_level[gi] = level_q;
      assign btn_pulse[gi] = pulse_q;
    end
  endgenerate

  // Switches share one counter; any bit moving restarts it so the vector updates atomically.
  logic [SW_WIDTH-1:0]  syn_sw_q;
  logic [SW_WIDTH-1:0]  sw_clean_q, sw_clean_d;
  logic [CNT_WIDTH-1:0] sw_cnt_q, sw_cnt_d;

  always_comb begin
    sw_cnt_d   = '0;
    sw_clean_d = sw_clean_q;
    if ((syn_sw == syn_sw_q) && (syn_sw != sw_clean_q)) begin
      if (sw_cnt_q == TERM_CNT) sw_clean_d = syn_sw;
      else                      sw_cnt_d   = sw_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rst0) begin
      syn_sw_q   <= '0;
      sw_clean_q <= '0;
      sw_cnt_q   <= '0;
    end else begin
      syn_sw_q   <= syn_sw;
      sw_clean_q <= sw_clean_d;
      sw_cnt_q   <= sw_cnt_d;
    end
  end

  assign sw_clean   = sw_clean_q;
  assign btnL_level = btn_level[0];
  assign btnR_level = btn_level[1];
  assign btnL_pulse = btn_pulse[0];
  assign btnR_pulse = btn_pulse[1];

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_board_input_conditioner;

  logic        clk0 = 1'b0;
  logic        rst0;
  logic [15:0] sw_raw;
  logic        btnL_raw, btnR_raw;
  logic [15:0] sw_clean;
  logic        btnL_level, btnR_level, btnL_pulse, btnR_pulse;

  int checks = 0;
  int errors = 0;

  board_input_conditioner #(
    .SW_WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)
  ) dut (
    .clk0(clk0), .rst0(rst0), .sw_raw(sw_raw), .btnL_raw(btnL_raw), .btnR_raw(btnR_raw),
    .sw_clean(sw_clean), .btnL_level(btnL_level), .btnR_level(btnR_level),
    .btnL_pulse(btnL_pulse), .btnR_pulse(btnR_pulse)
  );

  always #5 clk0 = ~clk0;

  // Advance one edge; outputs are sampled and inputs driven 1 time unit after it.
  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b0; sw_raw = 16'hFFFF; btnL_raw = 1'b1; btnR_raw = 1'b1;
    repeat (3) step();
    checks++;
    if ({sw_clean, btnL_level, btnR_level, btnL_pulse, btnR_pulse} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got sw=%h lvl=%b%b pls=%b%b exp all 0",
               sw_clean, btnL_level, btnR_level, btnL_pulse, btnR_pulse);
    end
    rst0 = 1'b1; sw_raw = 16'h0000; btnL_raw = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      step();
      checks++;
      if (btnR_pulse !== (n == 6) || btnR_level !== (n >= 6) || btnL_level !== 1'b0) begin
        errors++;
        $display("FAIL release_btnR edge=%0d got pulse=%b level=%b L=%b exp pulse=%b level=%b L=0",
                 n, btnR_pulse, btnR_level, btnL_level, (n == 6), (n >= 6));
      end
    end
  endtask

  task automatic test_bounce();
    btnR_raw = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      checks++;
      if (btnR_level !== (n < 6) || btnR_pulse !== 1'b0) begin
        errors++;
        $display("FAIL btnR_fall edge=%0d got level=%b pulse=%b exp level=%b pulse=0",
                 n, btnR_level, btnR_pulse, (n < 6));
      end
    end
    for (int b = 0; b < 4; b++) begin
      btnR_raw = (b % 2 == 0);
      step();
      checks++;
      if (btnR_level !== 1'b0 || btnR_pulse !== 1'b0) begin
        errors++;
        $display("FAIL bounce phase=%0d got level=%b pulse=%b exp 0 0", b, btnR_level, btnR_pulse);
      end
    end
    btnR_raw = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      step();
      checks++;
      if (btnR_pulse !== (n == 6) || btnR_level !== (n >= 6)) begin
        errors++;
        $display("FAIL bounce_hold edge=%0d got pulse=%b level=%b exp pulse=%b level=%b",
                 n, btnR_pulse, btnR_level, (n == 6), (n >= 6));
      end
    end
  endtask

  task automatic test_short_glitch();
    btnL_raw = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      if (n == 4) btnL_raw = 1'b0;
      step();
      checks++;
      if (btnL_level !== 1'b0 || btnL_pulse !== 1'b0) begin
        errors++;
        $display("FAIL btnL_glitch edge=%0d got level=%b pulse=%b exp 0 0", n, btnL_level, btnL_pulse);
      end
    end
  endtask

  task automatic test_switch();
    sw_raw = 16'hA5A5;
    for (int n = 1; n <= 3; n++) begin
      step();
      checks++;
      if (sw_clean !== 16'h0000) begin
        errors++;
        $display("FAIL sw_first edge=%0d got %h exp 0000", n, sw_clean);
      end
    end
    sw_raw = 16'hA5A4;
    for (int n = 1; n <= 10; n++) begin
      step();
      checks++;
      if (sw_clean !== ((n >= 7) ? 16'hA5A4 : 16'h0000)) begin
        errors++;
        $display("FAIL sw_second edge=%0d got %h exp %h", n, sw_clean,
                 (n >= 7) ? 16'hA5A4 : 16'h0000);
      end
    end
  endtask

  task automatic test_both_buttons();
    btnR_raw = 1'b0;
    repeat (8) step();
    checks++;
    if (btnR_level !== 1'b0) begin
      errors++;
      $display("FAIL both_prep got btnR_level=%b exp 0", btnR_level);
    end
    btnL_raw = 1'b1; btnR_raw = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      checks++;
      if (btnL_pulse !== (n == 6) || btnR_pulse !== (n == 6) ||
          btnL_level !== (n >= 6) || btnR_level !== (n >= 6)) begin
        errors++;
        $display("FAIL both_rise edge=%0d got pls=%b%b lvl=%b%b exp pls=%b lvl=%b",
                 n, btnL_pulse, btnR_pulse, btnL_level, btnR_level, (n == 6), (n >= 6));
      end
    end
    btnL_raw = 1'b0; btnR_raw = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      checks++;
      if (btnL_pulse !== 1'b0 || btnR_pulse !== 1'b0 ||
          btnL_level !== (n < 6) || btnR_level !== (n < 6)) begin
        errors++;
        $display("FAIL both_fall edge=%0d got pls=%b%b lvl=%b%b exp pls=0 lvl=%b",
                 n, btnL_pulse, btnR_pulse, btnL_level, btnR_level, (n < 6));
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    btnL_raw = 1'b1;
    repeat (4) step();
    checks++;
    if (btnL_level !== 1'b0 || btnL_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre_reset got level=%b pulse=%b exp 0 0", btnL_level, btnL_pulse);
    end
    rst0 = 1'b0;
    step();
    checks++;
    if ({sw_clean, btnL_level, btnR_level, btnL_pulse, btnR_pulse} !== 20'h0) begin
      errors++;
      $display("FAIL mid_reset got sw=%h lvl=%b%b pls=%b%b exp all 0",
               sw_clean, btnL_level, btnR_level, btnL_pulse, btnR_pulse);
    end
    rst0 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      checks++;
      if (btnL_pulse !== (n == 6) || btnL_level !== (n >= 6)) begin
        errors++;
        $display("FAIL mid_restart edge=%0d got pulse=%b level=%b exp pulse=%b level=%b",
                 n, btnL_pulse, btnL_level, (n == 6), (n >= 6));
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_short_glitch();
    test_switch();
    test_both_buttons();
    test_reset_mid_debounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
